// File: rtl/seg7_mux_counter.sv
// seg7_mux_counter
// Multi-digit hex counter with a time-multiplexed, active-low seven-segment
// driver for common-anode displays.
//
// A prescaler produces a one-cycle tick every TICK_DIV clocks. On each tick
// the counter steps up or down when run_i is high. A parallel load wins over
// the tick. A scan divider cycles through the digits, and the segments, digit
// select and decimal point are registered together.
//
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
// digits. Digit 0 is never blanked.
//
// Ports:
//   clockIn       system clock
//   n_reset       synchronous active-low reset
//   run_i         1 = count on tick, 0 = hold (prescaler keeps running)
//   up_down_i     1 = increment, 0 = decrement
//   load_i        single-cycle parallel load strobe
//   load_value_i  value loaded when load_i = 1
//   count_o       current counter value, digit 0 in bits [3:0]
//   tick_o        one-cycle pulse after prescaler terminal count
//   segment7_o    active-low segments {g,f,e,d,c,b,a}
//   dp_o          active-low decimal point (blinks on digit 0)
//   digit_en_o    active-low one-hot digit select
module seg7_mux_counter #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned DIGITS     = 4
) (
  input  logic                  clockIn,
  input  logic                  n_reset,
  input  logic                  run_i,
  input  logic                  up_down_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_value_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  tick_o,
  output logic [6:0]            segment7_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     digit_en_o
);

  localparam int unsigned CW       = 4 * DIGITS;
  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int unsigned PW       = $clog2(TICK_DIV);
  localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] P_TERM = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
  localparam logic [SW-1:0] S_TERM = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [PW-1:0]     presc_q,    presc_d;
  logic [SW-1:0]     scan_div_q, scan_div_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [CW-1:0]     count_q,    count_d;
  logic              tick_q,     tick_d;
  logic [6:0]        seg_q,      seg_d;
  logic              dp_q,       dp_d;
  logic [DIGITS-1:0] den_q,      den_d;

  logic              presc_term_c;
  logic              scan_term_c;
  logic [3:0]        nib_c;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic              blank_c;
`endif

  // Next-state for prescaler, counter, scan and the registered display.
  always_comb begin
    presc_term_c = (presc_q == P_TERM);
    scan_term_c  = (scan_div_q == S_TERM);

    presc_d    = presc_term_c ? '0 : presc_q + PW'(1);
    tick_d     = presc_term_c;
    scan_div_d = scan_term_c ? '0 : scan_div_q + SW'(1);
    scan_idx_d = scan_idx_q;
    if (scan_term_c) begin
      scan_idx_d = (scan_idx_q == I_LAST) ? '0 : scan_idx_q + IW'(1);
    end

    // Load has priority over the tick; the prescaler is unaffected by load.
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (presc_term_c && run_i) begin
      count_d = up_down_i ? count_q + CW'(1) : count_q - CW'(1);
    end

    nib_c = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank_c = 1'b0;
`endif
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (scan_idx_q == IW'(k)) begin
        nib_c = count_q[4*k +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Blank when this nibble and everything above it is zero.
        blank_c = (k != 0) && ((count_q >> (4*k)) == '0);
`endif
      end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    seg_d = blank_c ? 7'b1111111 : seg_decode(nib_c);
`else
    seg_d = seg_decode(nib_c);
`endif
    den_d = ~(DIGITS'(1) << scan_idx_q);
    dp_d  = ~((scan_idx_q == '0) && (presc_q < P_HALF));
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clockIn) begin
    if (!n_reset) begin
      presc_q    <= '0;
      scan_div_q <= '0;
      scan_idx_q <= '0;
      count_q    <= '0;
      tick_q     <= 1'b0;
      seg_q      <= 7'b1000000;
      dp_q       <= 1'b1;
      den_q      <= ~DIGITS'(1);
    end else begin
      presc_q    <= presc_d;
      scan_div_q <= scan_div_d;
      scan_idx_q <= scan_idx_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      den_q      <= den_d;
    end
  end

  assign count_o    = count_q;
  assign tick_o     = tick_q;
  assign segment7_o = seg_q;
  assign dp_o       = dp_q;
  assign digit_en_o = den_q;

endmodule
